perceptron_train_sequencer: RTL

PERCEPTRON_TRAIN_SEQUENCER -- requirements
Module: perceptron_train_sequencer

---
 rtl/perceptron_train_sequencer_pkg.sv | 44 ++++
 rtl/perceptron_train_sequencer_if.sv | 22 ++
 rtl/perceptron_train_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/perceptron_train_sequencer_pkg.sv
// Shared types for the perceptron training sequencer: fixed-point format,
// FSM state encoding and the AND-gate sample table.

package FixedPoint;
  localparam int unsigned SFP_W    = 16;
  localparam int unsigned SFP_FRAC = 8;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp ZERO = '0;
  localparam sfp ONE  = sfp'(1 << SFP_FRAC);
  localparam sfp HALF = sfp'(1 << (SFP_FRAC - 1));

  function automatic sfp int_to_sfp(input int x);
    return sfp'(x << SFP_FRAC);
  endfunction
endpackage

package Common;
  import FixedPoint::*;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    INFER_LOAD,
    INFER_WAIT
  } state_e;

  typedef struct packed {
    sfp a;
    sfp b;
    sfp target;
  } sample_t;

  localparam int unsigned AND_DEPTH = 4;

  localparam sample_t AND_TABLE [AND_DEPTH] = '{
    '{ZERO, ZERO, ZERO},
    '{ZERO, ONE,  ZERO},
    '{ONE,  ZERO, ZERO},
    '{ONE,  ONE,  ONE }
  };
endpackage

// File: rtl/perceptron_train_sequencer_if.sv
// Step handshake between the training sequencer (master) and the perceptron (slave).

interface perceptron_train_sequencer_if;
  import FixedPoint::*;

  logic     step_valid;
  logic     step_done;
  logic     training;
  sfp       prediction;
  sfp       expected;
  sfp [1:0] values;

  modport master (
    output step_valid, training, values, expected,
    input  step_done, prediction
  );

  modport slave (
    input  step_valid, training, values, expected,
    output step_done, prediction
  );
endinterface

// File: rtl/perceptron_train_sequencer.sv
// Drives a perceptron through NUM_EPOCHS passes of the AND table, then loops inference forever.
// Optional PTS_EARLY_STOP_EN: leave training as soon as an epoch is predicted fully correctly.

module perceptron_train_sequencer
  import FixedPoint::*;
  import Common::*;
#(
  parameter int unsigned NUM_EPOCHS  = 10,
  parameter int unsigned NUM_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        first_input,
  input  logic        second_input,
  perceptron_train_sequencer_if.master pif,
  output logic [15:0] epoch,
  output logic        busy,
  output logic        output_led
`ifdef PTS_EARLY_STOP_EN
  ,
  output logic        early_stop
`endif
);

  localparam int unsigned IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      epoch_q, epoch_d, epoch_inc;
  logic             step_valid_q, step_valid_d;
  logic             training_q, training_d;
  logic             busy_q, busy_d;
  logic             led_q, led_d;
  sfp [1:0]         values_q, values_d;
  sfp               expected_q, expected_d;

`ifdef PTS_EARLY_STOP_EN
  localparam int unsigned CNT_W = $clog2(NUM_SAMPLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             es_q, es_d, correct;
`endif

  // Next-state and next-output logic; outputs are registered one cycle after the deciding state.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    epoch_d      = epoch_q;
    step_valid_d = 1'b0;
    training_d   = training_q;
    led_d        = led_q;
    values_d     = values_q;
    expected_d   = expected_q;
    epoch_inc    = (epoch_q == 16'hFFFF) ? epoch_q : epoch_q + 16'd1;
`ifdef PTS_EARLY_STOP_EN
    cnt_d   = cnt_q;
    es_d    = es_q;
    correct = (pif.prediction > HALF) == (expected_q == ONE);
    cnt_inc = cnt_q + CNT_W'(correct);
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          epoch_d = '0;
          state_d = (NUM_EPOCHS == 0) ? INFER_LOAD : LOAD;
`ifdef PTS_EARLY_STOP_EN
          cnt_d = '0;
          es_d  = 1'b0;
`endif
        end
      end
      LOAD: begin
        values_d[0]  = AND_TABLE[idx_q].a;
        values_d[1]  = AND_TABLE[idx_q].b;
        expected_d   = AND_TABLE[idx_q].target;
        training_d   = 1'b1;
        step_valid_d = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        if (pif.step_done) begin
          if (32'(idx_q) == NUM_SAMPLES - 1) begin
            idx_d   = '0;
            epoch_d = epoch_inc;
            state_d = (32'(epoch_inc) == NUM_EPOCHS) ? INFER_LOAD : LOAD;
`ifdef PTS_EARLY_STOP_EN
            cnt_d = '0;
            if (cnt_inc == CNT_W'(NUM_SAMPLES)) begin
              state_d = INFER_LOAD;
              es_d    = 1'b1;
            end
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = LOAD;
`ifdef PTS_EARLY_STOP_EN
            cnt_d = cnt_inc;
`endif
          end
        end
      end
      INFER_LOAD: begin
        values_d[0]  = int_to_sfp(int'(first_input));
        values_d[1]  = int_to_sfp(int'(second_input));
        expected_d   = ZERO;
        training_d   = 1'b0;
        step_valid_d = 1'b1;
        state_d      = INFER_WAIT;
      end
      INFER_WAIT: begin
        if (pif.step_done) begin
          led_d   = pif.prediction > HALF;
          state_d = INFER_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      epoch_q      <= '0;
      step_valid_q <= 1'b0;
      training_q   <= 1'b0;
      busy_q       <= 1'b0;
      led_q        <= 1'b0;
      values_q     <= '0;
      expected_q   <= ZERO;
`ifdef PTS_EARLY_STOP_EN
      cnt_q <= '0;
      es_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      epoch_q      <= epoch_d;
      step_valid_q <= step_valid_d;
      training_q   <= training_d;
      busy_q       <= busy_d;
      led_q        <= led_d;
      values_q     <= values_d;
      expected_q   <= expected_d;
`ifdef PTS_EARLY_STOP_EN
      cnt_q <= cnt_d;
      es_q  <= es_d;
`endif
    end
  end

  assign pif.step_valid = step_valid_q;
  assign pif.training   = training_q;
  assign pif.values     = values_q;
  assign pif.expected   = expected_q;
  assign epoch          = epoch_q;
  assign busy           = busy_q;
  assign output_led     = led_q;
`ifdef PTS_EARLY_STOP_EN
  assign early_stop = es_q;
`endif

endmodule
